zbus_arbiter: RTL and testbench
===============================

# zbus_arbiter

Multi-initiator side of the zbus interconnect: merges BN initiator zbus ports onto one target port. Round-robin arbitration picks one valid initiator and forwards its valid, lock and grouped bus to the output, returning the output acknowledge to that initiator only. Lock requests keep the grant across transfers. The block sits upstream of a target or a zbus de-multiplexer and is the return path for the de-multiplexing fabric.

## Interface
- BW, 32: width of the grouped bus signals per port.
- BN, 2: number of initiator ports (≥2, need not be a power of two).
- BNL, $clog2(BN): index width.

- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- zi_vld  input  BN  per-initiator transfer valid.
- zi_lck  input  BN  per-initiator arbiter lock request.
- zi_bus  input  BW*BN  per-initiator grouped bus; port i at [i*BW+:BW].
- zi_ack  output  BN  per-initiator transfer acknowledge.
- zo_vld  output  1  merged transfer valid.
- zo_lck  output  1  lock of the granted initiator.
- zo_bus  output  BW  bus of the granted initiator.
- zo_ack  input  1  target acknowledge.
- gnt  output  BN  one-hot of the initiator currently forwarded; all-zero when none.

## Operation
- Transfer: a cycle with zo_vld & zo_ack. An initiator holds zi_vld, zi_bus and zi_lck stable until acknowledged.
- Registered state: fsm (IDLE, WAIT, LOCK), sel (BNL bits, held winner), ptr (BNL bits, last served).
- Arbitration, IDLE only: combinational scan of zi_vld starting at (ptr+1) mod BN, ascending, wrapping mod BN; the first set bit is winner w. No bit set: no grant.
- Forwarding: w in IDLE, sel in WAIT/LOCK. zo_vld = zi_vld[g], zo_lck = zi_lck[g], zo_bus = zi_bus[g], zi_ack[g] = zo_ack, gnt[g] = 1. Every other zi_ack bit is 0. With no grant, zo_vld = zo_lck = 0, zo_bus = 0, zi_ack = 0, gnt = 0.
- IDLE:
  - winner and zo_ack: transfer. ptr<=w. Go to LOCK with sel<=w if zi_lck[w], otherwise stay IDLE.
  - winner, no ack: sel<=w, go to WAIT. The grant is now frozen.
- WAIT:
  - zo_ack: ptr<=sel. Go to LOCK if zi_lck[sel], else IDLE.
  - zi_vld[sel]=0 (protocol violation): go to IDLE, ptr unchanged.
  - Otherwise hold.
- LOCK: only sel is served; other initiators wait regardless of priority.
  - Transfer with zi_lck[sel]=0: ptr<=sel, go to IDLE.
  - Transfer with zi_lck[sel]=1: stay in LOCK.
  - zi_vld[sel]=0 and zi_lck[sel]=0: release to IDLE, no transfer.
  - zi_vld[sel]=0 and zi_lck[sel]=1: hold LOCK with zo_vld=0.
- Widths: ptr+1 wraps from BN-1 to 0 explicitly; BN is not assumed to be 2^BNL.

## Timing
- Reset: fsm=IDLE, sel=0, ptr=BN-1, so initiator 0 has first priority. All outputs follow combinationally; with zi_vld=0 every output is 0.
- Latency: zero cycles input to output. vld/lck/bus to zo_*, and zo_ack to zi_ack, are combinational paths. The only registered effects are grant state and priority.
- Back-to-back: one transfer per cycle sustained. A new initiator can win in the cycle after an IDLE-state transfer.
- Fairness: with all inputs continuously valid and unlocked, grants rotate 0,1,…,BN-1,0.
- Simultaneous: a request appearing in the same cycle another initiator's transfer completes sees the updated ptr only on the next cycle.
- Reset mid-operation (WAIT or LOCK): immediate return to reset state. Outputs drop in the same cycle and any in-flight grant is lost.

## Test plan
- Reset, BN=4, BW=8, zi_vld=0 -> zo_vld=0, zo_bus=0x00, gnt=0, zi_ack=0. Then zi_vld=4'b1111 with zo_ack=1 for 5 cycles -> gnt sequence 1,2,4,8,1.
- zi_vld[2]=1, bus2=0xA5, zo_ack=0 for 3 cycles, then zi_vld[0] rises -> gnt stays 4'b0100 and zo_bus stays 0xA5 until zo_ack. The next cycle grants input 0.
- Input 1 transfers with zi_lck[1]=1 (3 acked transfers, lck falls on the 3rd) while zi_vld[3]=1 throughout -> zi_ack[3]=0 for all 3 transfers; input 3 granted in the cycle after the release.
- LOCK with zi_vld[1]=0 and zi_lck[1]=1 for 2 cycles -> zo_vld=0, zo_lck=1, gnt=4'b0010. Dropping zi_lck[1] -> IDLE next cycle.
- BN=3 with all valid and zo_ack=1 -> gnt wraps 1,2,4,1 and index 3 is never produced.
- Assert rst during WAIT on input 2 -> outputs 0 in the same cycle. After release, input 0 wins over input 2 when both are valid.

Source files
------------

// File: rtl/zbus_arbiter.sv
// zbus_arbiter
//   Merges BN initiator zbus ports onto a single target port. A round-robin
//   scan picks one valid initiator; its valid, lock and grouped bus are
//   forwarded to the target and the target acknowledge is routed back to it
//   alone. A lock request keeps the grant on the same initiator across
//   transfers.
//
// Parameters
//   BW   width of the grouped bus per port
//   BN   number of initiator ports (>= 2, any value)
//   BNL  index width, $clog2(BN)
//
// Ports
//   clk     system clock
//   rst     asynchronous active-high reset
//   zi_vld  [BN]     per-initiator transfer valid
//   zi_lck  [BN]     per-initiator lock request
//   zi_bus  [BW*BN]  per-initiator bus, port i at [i*BW +: BW]
//   zi_ack  [BN]     per-initiator acknowledge (only the granted one)
//   zo_vld           merged transfer valid
//   zo_lck           lock of the granted initiator
//   zo_bus  [BW]     bus of the granted initiator
//   zo_ack           target acknowledge
//   gnt     [BN]     one-hot of the forwarded initiator, zero when none
module zbus_arbiter #(
    parameter int BW  = 32,
    parameter int BN  = 2,
    parameter int BNL = $clog2(BN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BN-1:0]    zi_vld,
    input  logic [BN-1:0]    zi_lck,
    input  logic [BW*BN-1:0] zi_bus,
    output logic [BN-1:0]    zi_ack,
    output logic             zo_vld,
    output logic             zo_lck,
    output logic [BW-1:0]    zo_bus,
    input  logic             zo_ack,
    output logic [BN-1:0]    gnt
);

    localparam int unsigned N = BN;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        LOCK
    } state_t;

    state_t         state, state_nxt;
    logic [BNL-1:0] sel, sel_nxt;
    logic [BNL-1:0] ptr, ptr_nxt;

    int unsigned    scan_start;
    logic           hi_vld, lo_vld;
    logic [BNL-1:0] hi_idx, lo_idx;
    logic           win_vld;
    logic [BNL-1:0] win;

    logic           gnt_vld;
    logic [BNL-1:0] gnt_idx;
    logic           cur_vld;
    logic           cur_lck;

    // Round-robin scan starting after the last served initiator. The wrap is
    // done as two ascending passes: the first set bit at or above the start
    // index wins, otherwise the first set bit below it. This avoids any
    // modulo on a non-power-of-two BN.
    always_comb begin
        scan_start = (32'(ptr) == N - 1) ? 0 : 32'(ptr) + 1;
        hi_vld     = 1'b0;
        hi_idx     = '0;
        lo_vld     = 1'b0;
        lo_idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!hi_vld && zi_vld[i] && (i >= scan_start)) begin
                hi_vld = 1'b1;
                hi_idx = BNL'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!lo_vld && zi_vld[i] && (i < scan_start)) begin
                lo_vld = 1'b1;
                lo_idx = BNL'(i);
            end
        end
        win_vld = hi_vld | lo_vld;
        win     = hi_vld ? hi_idx : lo_idx;
    end

    // Granted index: live winner in IDLE, frozen selection otherwise.
    // Reset also masks the grant combinationally so the outputs drop in the
    // same cycle reset is raised, even while an initiator is still valid.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (!rst) begin
            if (state == IDLE) begin
                gnt_vld = win_vld;
                gnt_idx = win;
            end else begin
                gnt_vld = 1'b1;
                gnt_idx = sel;
            end
        end
    end

    // Output multiplexer driven by the granted index.
    always_comb begin
        gnt     = '0;
        cur_vld = 1'b0;
        cur_lck = 1'b0;
        zo_bus  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_vld && (gnt_idx == BNL'(i))) begin
                gnt[i]  = 1'b1;
                cur_vld = zi_vld[i];
                cur_lck = zi_lck[i];
                zo_bus  = zi_bus[i*BW +: BW];
            end
        end
    end

    assign zo_vld = cur_vld;
    assign zo_lck = cur_lck;
    assign zi_ack = gnt & {BN{zo_ack}};

    // Next-state logic. Outside IDLE the granted initiator is sel, so
    // cur_vld/cur_lck are zi_vld[sel]/zi_lck[sel]; in IDLE they belong to
    // the winner.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    if (zo_ack) begin
                        ptr_nxt = win;
                        if (cur_lck) begin
                            state_nxt = LOCK;
                            sel_nxt   = win;
                        end
                    end else begin
                        sel_nxt   = win;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (zo_ack) begin
                    ptr_nxt   = sel;
                    state_nxt = cur_lck ? LOCK : IDLE;
                end else if (!cur_vld) begin
                    // initiator withdrew before acknowledge
                    state_nxt = IDLE;
                end
            end
            LOCK: begin
                if (cur_vld && zo_ack) begin
                    if (!cur_lck) begin
                        ptr_nxt   = sel;
                        state_nxt = IDLE;
                    end
                end else if (!cur_vld && !cur_lck) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= BNL'(BN - 1);
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_zbus_arbiter.sv
// tb_zbus_arbiter
//   Two arbiter instances (BN=4 and BN=3, BW=8) checked every cycle against a
//   behavioural model that tracks the current owner, whether it is locked,
//   and the last served index. Directed scenarios come first, then random
//   protocol-legal traffic with occasional resets.
module tb_zbus_arbiter;

    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]    vld  [2];
    logic [3:0]    lck  [2];
    logic [BW-1:0] bus  [2][4];
    logic          oack [2];

    logic [3:0]    ack4, gnt4;
    logic          vo4, lo4;
    logic [BW-1:0] bo4;
    logic [2:0]    ack3, gnt3;
    logic          vo3, lo3;
    logic [BW-1:0] bo3;

    zbus_arbiter #(.BW(BW), .BN(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .zi_vld (vld[0]),
        .zi_lck (lck[0]),
        .zi_bus ({bus[0][3], bus[0][2], bus[0][1], bus[0][0]}),
        .zi_ack (ack4),
        .zo_vld (vo4),
        .zo_lck (lo4),
        .zo_bus (bo4),
        .zo_ack (oack[0]),
        .gnt    (gnt4)
    );

    zbus_arbiter #(.BW(BW), .BN(3)) dut3 (
        .clk    (clk),
        .rst    (rst),
        .zi_vld (vld[1][2:0]),
        .zi_lck (lck[1][2:0]),
        .zi_bus ({bus[1][2], bus[1][1], bus[1][0]}),
        .zi_ack (ack3),
        .zo_vld (vo3),
        .zo_lck (lo3),
        .zo_bus (bo3),
        .zo_ack (oack[1]),
        .gnt    (gnt3)
    );

    int n_checks = 0;
    int n_errors = 0;

    int         nports [2] = '{4, 3};
    int         m_own  [2];   // current owner, -1 when none
    bit         m_lk   [2];   // owner holds a lock
    int         m_last [2];   // last served index
    logic [3:0] acked  [2];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = -1;
            m_lk[k]   = 1'b0;
            m_last[k] = nports[k] - 1;
        end
    endfunction

    // Which initiator should be forwarded right now (-1 for none).
    function automatic int pick(int k);
        int i;
        if (rst !== 1'b0) return -1;
        if (m_own[k] >= 0) return m_own[k];
        for (int d = 1; d <= nports[k]; d++) begin
            i = (m_last[k] + d) % nports[k];
            if (vld[k][i]) return i;
        end
        return -1;
    endfunction

    task automatic compare(string tag);
        int            g;
        logic [3:0]    eg, ea, og, oa;
        logic          ev, el, ov, ol;
        logic [BW-1:0] eb, ob;
        for (int k = 0; k < 2; k++) begin
            g  = pick(k);
            eg = '0;
            ea = '0;
            ev = 1'b0;
            el = 1'b0;
            eb = '0;
            if (g >= 0) begin
                eg[g] = 1'b1;
                ev    = vld[k][g];
                el    = lck[k][g];
                eb    = bus[k][g];
                if (oack[k]) ea = eg;
            end
            if (k == 0) begin
                og = gnt4; oa = ack4; ov = vo4; ol = lo4; ob = bo4;
            end else begin
                og = {1'b0, gnt3}; oa = {1'b0, ack3}; ov = vo3; ol = lo3; ob = bo3;
            end
            acked[k] = ea & vld[k];
            check($sformatf("%s bn%0d gnt", tag, nports[k]), 32'(og), 32'(eg));
            check($sformatf("%s bn%0d zi_ack", tag, nports[k]), 32'(oa), 32'(ea));
            check($sformatf("%s bn%0d zo_vld", tag, nports[k]), 32'(ov), 32'(ev));
            check($sformatf("%s bn%0d zo_lck", tag, nports[k]), 32'(ol), 32'(el));
            check($sformatf("%s bn%0d zo_bus", tag, nports[k]), 32'(ob), 32'(eb));
        end
    endtask

    // Advance the model with the inputs present at the clock edge.
    function automatic void model_update();
        int g;
        bit xfer;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            g = pick(k);
            if (g < 0) continue;
            xfer = vld[k][g] && oack[k];
            if (m_own[k] < 0) begin
                if (xfer) begin
                    m_last[k] = g;
                    if (lck[k][g]) begin
                        m_own[k] = g;
                        m_lk[k]  = 1'b1;
                    end
                end else begin
                    m_own[k] = g;
                    m_lk[k]  = 1'b0;
                end
            end else if (!m_lk[k]) begin
                if (oack[k]) begin
                    m_last[k] = g;
                    if (lck[k][g]) m_lk[k] = 1'b1;
                    else m_own[k] = -1;
                end else if (!vld[k][g]) begin
                    m_own[k] = -1;
                end
            end else begin
                if (xfer) begin
                    if (!lck[k][g]) begin
                        m_last[k] = g;
                        m_own[k]  = -1;
                        m_lk[k]   = 1'b0;
                    end
                end else if (!vld[k][g] && !lck[k][g]) begin
                    m_own[k] = -1;
                    m_lk[k]  = 1'b0;
                end
            end
        end
    endfunction

    task automatic settle(string tag);
        @(negedge clk);
        compare(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Protocol-legal random drive: a request is held until acknowledged.
    task automatic rand_drive();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < nports[k]; i++) begin
                if (!vld[k][i] || acked[k][i]) begin
                    vld[k][i] = ($urandom_range(0, 2) != 0);
                    lck[k][i] = ($urandom_range(0, 3) == 0);
                    bus[k][i] = BW'($urandom);
                end
            end
            oack[k] = 1'($urandom_range(0, 1));
        end
        rst = ($urandom_range(0, 299) == 0);
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            vld[k]   = '0;
            lck[k]   = '0;
            oack[k]  = 1'b0;
            acked[k] = '0;
            for (int i = 0; i < 4; i++) bus[k][i] = '0;
        end
    endtask

    logic [3:0] rr_seq4 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] rr_seq3 [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();

        // Reset state
        settle("reset");
        check("reset gnt", 32'(gnt4), 32'(0));
        check("reset zo_bus", 32'(bo4), 32'(0));
        tick();
        rst = 1'b0;
        settle("idle");
        check("idle zo_vld", 32'(vo4), 32'(0));
        check("idle zi_ack", 32'(ack4), 32'(0));
        tick();

        // Fairness, all four valid and acknowledged
        vld[0]  = 4'b1111;
        oack[0] = 1'b1;
        for (int i = 0; i < 4; i++) bus[0][i] = BW'(8'h10 + i);
        for (int j = 0; j < 5; j++) begin
            settle("rr4");
            check($sformatf("rr4 gnt[%0d]", j), 32'(gnt4), 32'(rr_seq4[j]));
            tick();
        end
        vld[0] = '0;
        tick();

        // Grant frozen while waiting for acknowledge
        vld[0]    = 4'b0100;
        bus[0][2] = 8'hA5;
        bus[0][0] = 8'h3C;
        oack[0]   = 1'b0;
        for (int j = 0; j < 3; j++) begin
            settle("wait");
            check("wait gnt", 32'(gnt4), 32'(4'b0100));
            tick();
        end
        vld[0][0] = 1'b1;
        for (int j = 0; j < 2; j++) begin
            settle("wait2");
            check("wait2 gnt", 32'(gnt4), 32'(4'b0100));
            check("wait2 zo_bus", 32'(bo4), 32'(8'hA5));
            tick();
        end
        oack[0] = 1'b1;
        settle("wait_ack");
        check("wait_ack zi_ack", 32'(ack4), 32'(4'b0100));
        tick();
        vld[0][2] = 1'b0;
        settle("after_wait");
        check("after_wait gnt", 32'(gnt4), 32'(4'b0001));
        tick();
        vld[0] = '0;
        tick();

        // Locked sequence on input 1 while input 3 waits
        vld[0]    = 4'b1010;
        lck[0]    = 4'b0010;
        bus[0][1] = 8'h11;
        bus[0][3] = 8'h33;
        oack[0]   = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (j == 2) lck[0][1] = 1'b0;
            settle("lock");
            check("lock gnt", 32'(gnt4), 32'(4'b0010));
            check("lock zi_ack3", 32'(ack4[3]), 32'(0));
            tick();
        end
        vld[0][1] = 1'b0;
        settle("lock_rel");
        check("lock_rel gnt", 32'(gnt4), 32'(4'b1000));
        tick();
        vld[0] = '0;
        tick();

        // Lock held with valid low, then released
        vld[0]  = 4'b0010;
        lck[0]  = 4'b0010;
        oack[0] = 1'b1;
        settle("lk_enter");
        tick();
        vld[0] = 4'b0001;
        lck[0] = 4'b0010;
        for (int j = 0; j < 2; j++) begin
            settle("lk_hold");
            check("lk_hold zo_vld", 32'(vo4), 32'(0));
            check("lk_hold zo_lck", 32'(lo4), 32'(1));
            check("lk_hold gnt", 32'(gnt4), 32'(4'b0010));
            tick();
        end
        lck[0] = '0;
        settle("lk_drop");
        tick();
        settle("lk_idle");
        check("lk_idle gnt", 32'(gnt4), 32'(4'b0001));
        tick();
        vld[0] = '0;
        tick();

        // BN=3 wrap
        vld[1]  = 4'b0111;
        oack[1] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            settle("rr3");
            check($sformatf("rr3 gnt[%0d]", j), 32'(gnt3), 32'(rr_seq3[j]));
            tick();
        end
        vld[1]  = '0;
        oack[1] = 1'b0;
        tick();

        // Reset during WAIT
        vld[0]    = 4'b0100;
        bus[0][2] = 8'h5A;
        oack[0]   = 1'b0;
        settle("rw_enter");
        tick();
        settle("rw_wait");
        check("rw_wait gnt", 32'(gnt4), 32'(4'b0100));
        rst = 1'b1;
        #1;
        compare("rw_rst");
        check("rw_rst gnt", 32'(gnt4), 32'(0));
        check("rw_rst zo_vld", 32'(vo4), 32'(0));
        tick();
        rst       = 1'b0;
        vld[0][0] = 1'b1;
        settle("rw_after");
        check("rw_after gnt", 32'(gnt4), 32'(4'b0001));
        tick();
        oack[0] = 1'b1;
        settle("rw_drain");
        tick();
        clear_inputs();
        settle("pre_rand");
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rand_drive();
            settle("rnd");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
